// File: rtl/switch_event_arbiter_pkg.sv
// Shared defaults and FSM encoding for the switch event arbiter.
package switch_event_arbiter_pkg;

    localparam int N_DEF  = 18;
    localparam int IW_DEF = 5;

    // Arbiter FSM: IDLE searches for a pending channel, PRESENT holds one event.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/switch_event_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping at N.
module switch_event_arbiter_rr_pick
    import switch_event_arbiter_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = IW_DEF
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] grant
);

    // Scan offsets 1..N from ptr; the last offset revisits ptr itself.
    always_comb begin
        int   idx;
        logic hit;
        any   = 1'b0;
        grant = '0;
        idx   = 0;
        hit   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            hit = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i == idx) hit = req[i];
            end
            if (!any && hit) begin
                any   = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Switch event arbiter: detects level changes on debounced switches, queues one
// pending flag per channel and presents them one at a time, round-robin, over a
// valid/ready handshake. Changes collapsed before service raise a sticky overflow.
module switch_event_arbiter
    import switch_event_arbiter_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  sw_clean,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [IW-1:0] evt_idx,
    output logic          evt_level,
    output logic [N-1:0]  pending,
    output logic          overflow,
    input  logic          clr_overflow
);

    state_e        state_q, state_d;
    logic [N-1:0]  sw_q, sw_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          level_q, level_d;

    logic [N-1:0]  chg;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          grant_fire;
    logic          accept;
    logic          lvl_sel;
    logic          ovf_set;

    switch_event_arbiter_rr_pick #(
        .N  (N),
        .IW (IW)
    ) rr_pick (
        .req   (pend_q),
        .ptr   (ptr_q),
        .any   (pick_any),
        .grant (pick_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: grant whenever something is pending, return on acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any)  state_d = PRESENT;
            PRESENT: if (evt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; evt_valid depends only on the state register, never on evt_ready.
    always_comb begin
        evt_valid  = (state_q == PRESENT);
        grant_fire = (state_q == IDLE) && pick_any;
        accept     = (state_q == PRESENT) && evt_ready;
    end

    // Change detection and per-channel pending/level bookkeeping; a new change
    // always beats the grant clear, and only counts as overflow when it lands on
    // a flag that is not being serviced this cycle.
    always_comb begin
        sw_d    = sw_clean;
        chg     = sw_clean ^ sw_q;
        pend_d  = pend_q;
        lvl_d   = lvl_q;
        ovf_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_fire && (pick_idx == IW'(i))) pend_d[i] = 1'b0;
            if (chg[i]) begin
                pend_d[i] = 1'b1;
                lvl_d[i]  = sw_clean[i];
                if (pend_q[i] && !(grant_fire && (pick_idx == IW'(i)))) ovf_set = 1'b1;
            end
        end
        ovf_d = ovf_q;
        if (clr_overflow) ovf_d = 1'b0;
        if (ovf_set)      ovf_d = 1'b1;
    end

    // Event payload captured at grant and held through PRESENT; ptr advances on accept.
    always_comb begin
        lvl_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) lvl_sel = lvl_q[i];
        end
        idx_d   = idx_q;
        level_d = level_q;
        ptr_d   = ptr_q;
        if (grant_fire) begin
            idx_d   = pick_idx;
            level_d = lvl_sel;
        end
        if (accept) ptr_d = idx_q;
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q    <= '0;
            pend_q  <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= IW'(N - 1);
            idx_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sw_q    <= sw_d;
            pend_q  <= pend_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            level_q <= level_d;
        end
    end

    assign evt_idx   = idx_q;
    assign evt_level = level_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule
